// File: rtl/vgpr_operand_collector_pkg.sv
// Shared widths and helpers for the VGPR operand collector: default field widths,
// number of source operands and the width of one buffered operand bundle.
package vgpr_operand_collector_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_TAG_W  = 6;
    localparam int NUM_SRC    = 3;

    // Bundle layout is {src2, src1, src0, tag}, tag in the least significant bits.
    function automatic int bundle_w(input int data_w, input int tag_w);
        return NUM_SRC * data_w + tag_w;
    endfunction

endpackage

// File: rtl/vgpr_operand_collector_if.sv
// Request, register-file and issue-side signals of the operand collector.
// The slave modport is the collector's view; master is the surrounding pipeline.
interface vgpr_operand_collector_if
    import vgpr_operand_collector_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W
) ();

    logic                in_valid;
    logic                in_ready;
    logic [NUM_SRC-1:0]  in_src_en;
    logic [ADDR_W-1:0]   in_src0_addr;
    logic [ADDR_W-1:0]   in_src1_addr;
    logic [ADDR_W-1:0]   in_src2_addr;
    logic [TAG_W-1:0]    in_tag;

    logic [ADDR_W-1:0]   rf_rd0_addr;
    logic [ADDR_W-1:0]   rf_rd1_addr;
    logic [ADDR_W-1:0]   rf_rd2_addr;
    logic [DATA_W-1:0]   rf_rd0_data;
    logic [DATA_W-1:0]   rf_rd1_data;
    logic [DATA_W-1:0]   rf_rd2_data;

    logic                wr0_en;
    logic [ADDR_W-1:0]   wr0_addr;
    logic [DATA_W-1:0]   wr0_data;

    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_src0;
    logic [DATA_W-1:0]   out_src1;
    logic [DATA_W-1:0]   out_src2;
    logic [TAG_W-1:0]    out_tag;

    modport slave (
        input  in_valid, in_src_en, in_src0_addr, in_src1_addr, in_src2_addr, in_tag,
        output in_ready,
        output rf_rd0_addr, rf_rd1_addr, rf_rd2_addr,
        input  rf_rd0_data, rf_rd1_data, rf_rd2_data,
        input  wr0_en, wr0_addr, wr0_data,
        output out_valid, out_src0, out_src1, out_src2, out_tag,
        input  out_ready
    );

    modport master (
        output in_valid, in_src_en, in_src0_addr, in_src1_addr, in_src2_addr, in_tag,
        input  in_ready,
        input  rf_rd0_addr, rf_rd1_addr, rf_rd2_addr,
        output rf_rd0_data, rf_rd1_data, rf_rd2_data,
        output wr0_en, wr0_addr, wr0_data,
        input  out_valid, out_src0, out_src1, out_src2, out_tag,
        output out_ready
    );

endinterface

// File: rtl/vgpr_operand_collector_operand_buf.sv
// Operand bundle FIFO: DEPTH x WIDTH circular buffer with occupancy count,
// simultaneous push/pop, and an overflow checker kept beside it.
module operand_buf_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign w_do_pop = i_pop && (r_count != '0);

    // Storage, pointers and occupancy; reset clears contents so the head reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ptr_inc(r_wptr);
            end
            if (w_do_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({i_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

    operand_buf_fifo_chk u_chk (
        .clk    (clk),
        .rst    (rst),
        .i_push (i_push),
        .i_full (r_count == CNT_W'(DEPTH))
    );

endmodule

// Upstream credit accounting must never let a bundle arrive at a full buffer.
module operand_buf_fifo_chk (
    input logic clk,
    input logic rst,
    input logic i_push,
    input logic i_full
);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_push && i_full));
endmodule

// File: rtl/vgpr_operand_collector.sv
// VGPR operand collector: issues register-file reads, forwards writes the array
// read misses, and queues assembled operand bundles for the ALU issue stage.
module vgpr_operand_collector
    import vgpr_operand_collector_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int DEPTH  = 4
) (
    input logic clk,
    input logic rst,
    vgpr_operand_collector_if.slave io_bus
);
    localparam int BUNDLE_W = bundle_w(DATA_W, TAG_W);
    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam int OCC_W    = CNT_W + 2;

    logic                w_accept;
    logic                w_pop;
    logic                w_empty;
    logic [CNT_W-1:0]    w_count;
    logic [OCC_W-1:0]    w_occupancy;
    logic [BUNDLE_W-1:0] w_push_data;
    logic [BUNDLE_W-1:0] w_head;
    logic [ADDR_W-1:0]   w_src_addr [NUM_SRC];
    logic [DATA_W-1:0]   w_rd_data  [NUM_SRC];
    logic [DATA_W-1:0]   w_operand  [NUM_SRC];
    logic [NUM_SRC-1:0]  w_s1_hit;

    logic                r_s1_v;
    logic [NUM_SRC-1:0]  r_s1_en;
    logic [TAG_W-1:0]    r_s1_tag;
    logic [ADDR_W-1:0]   r_rd_addr [NUM_SRC];

    logic                r_s2_v;
    logic [NUM_SRC-1:0]  r_s2_en;
    logic [TAG_W-1:0]    r_s2_tag;
    logic [ADDR_W-1:0]   r_s2_addr [NUM_SRC];
    logic [NUM_SRC-1:0]  r_s2_hit;
    logic [DATA_W-1:0]   r_s2_fwd_data [NUM_SRC];

    // Gather the per-source ports into arrays for the per-source loops.
    always_comb begin
        w_src_addr[0] = io_bus.in_src0_addr;
        w_src_addr[1] = io_bus.in_src1_addr;
        w_src_addr[2] = io_bus.in_src2_addr;
        w_rd_data[0]  = io_bus.rf_rd0_data;
        w_rd_data[1]  = io_bus.rf_rd1_data;
        w_rd_data[2]  = io_bus.rf_rd2_data;
    end

    // Credits count every request already past accept, so the pipe never needs to stall.
    assign w_occupancy     = OCC_W'(r_s1_v) + OCC_W'(r_s2_v) + OCC_W'(w_count);
    assign io_bus.in_ready = !rst && (w_occupancy < OCC_W'(DEPTH));
    assign w_accept        = io_bus.in_valid && io_bus.in_ready;
    assign w_pop           = !w_empty && io_bus.out_ready;

    // Address stage: read addresses are loaded on accept and held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v   <= 1'b0;
            r_s1_en  <= '0;
            r_s1_tag <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                r_rd_addr[i] <= '0;
            end
        end else begin
            r_s1_v <= w_accept;
            if (w_accept) begin
                r_s1_en  <= io_bus.in_src_en;
                r_s1_tag <= io_bus.in_tag;
                for (int i = 0; i < NUM_SRC; i++) begin
                    r_rd_addr[i] <= w_src_addr[i];
                end
            end
        end
    end

    // A write during the address cycle lands too late for the array read.
    always_comb begin
        w_s1_hit = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_s1_hit[i] = r_s1_v && r_s1_en[i] && io_bus.wr0_en &&
                          (io_bus.wr0_addr == r_rd_addr[i]);
        end
    end

    // Data stage registers: carry the request plus any address-cycle forward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_v   <= 1'b0;
            r_s2_en  <= '0;
            r_s2_tag <= '0;
            r_s2_hit <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                r_s2_addr[i]     <= '0;
                r_s2_fwd_data[i] <= '0;
            end
        end else begin
            r_s2_v   <= r_s1_v;
            r_s2_en  <= r_s1_en;
            r_s2_tag <= r_s1_tag;
            r_s2_hit <= w_s1_hit;
            for (int i = 0; i < NUM_SRC; i++) begin
                r_s2_addr[i]     <= r_rd_addr[i];
                r_s2_fwd_data[i] <= io_bus.wr0_data;
            end
        end
    end

    // Operand select: youngest write wins, disabled sources read as zero.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            w_operand[i] = '0;
            if (!r_s2_en[i]) begin
                w_operand[i] = '0;
            end else if (io_bus.wr0_en && (io_bus.wr0_addr == r_s2_addr[i])) begin
                w_operand[i] = io_bus.wr0_data;
            end else if (r_s2_hit[i]) begin
                w_operand[i] = r_s2_fwd_data[i];
            end else begin
                w_operand[i] = w_rd_data[i];
            end
        end
    end

    assign w_push_data = {w_operand[2], w_operand[1], w_operand[0], r_s2_tag};

    operand_buf_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BUNDLE_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_s2_v),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    assign io_bus.rf_rd0_addr = r_rd_addr[0];
    assign io_bus.rf_rd1_addr = r_rd_addr[1];
    assign io_bus.rf_rd2_addr = r_rd_addr[2];
    assign io_bus.out_valid   = !w_empty;
    assign io_bus.out_tag     = w_head[TAG_W-1:0];
    assign io_bus.out_src0    = w_head[TAG_W +: DATA_W];
    assign io_bus.out_src1    = w_head[TAG_W + DATA_W +: DATA_W];
    assign io_bus.out_src2    = w_head[TAG_W + 2 * DATA_W +: DATA_W];

endmodule

// File: doc/vgpr_operand_collector.md
Name: vgpr_operand_collector

Overview:
Upstream of the 1024x32b, 3-read/1-write vector register file. Accepts one operand-fetch request per cycle (up to three source addresses plus a tag), drives the register file read addresses, and captures the registered read data one cycle later. Forwards same-cycle register-file writes that the array read misses. Buffers the assembled operands behind a valid/ready handshake to the ALU issue stage.

Parameters:
ADDR_W, 10, register file address width (1024 entries)
DATA_W, 32, operand width
TAG_W, 6, opaque request tag (wavefront/slot id), passed through unchanged
DEPTH, 4, operand buffer entries; must be at least 1; DEPTH>=4 required for 1 req/cycle sustained throughput

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid&in_ready
in_src_en  in  3  per-source enable, bit i = source i used
in_src0_addr/in_src1_addr/in_src2_addr  in  ADDR_W each  source register addresses
in_tag  in  TAG_W  request tag
rf_rd0_addr/rf_rd1_addr/rf_rd2_addr  out  ADDR_W each  to register file read ports
rf_rd0_data/rf_rd1_data/rf_rd2_data  in  DATA_W each  register file read data, valid one cycle after address
wr0_en/wr0_addr/wr0_data  in  1/ADDR_W/DATA_W  snoop of register file write port, same cycle as array write
out_valid  out  1  operand bundle valid
out_ready  in  1  consumer accept
out_src0/out_src1/out_src2  out  DATA_W each  operands
out_tag  out  TAG_W  tag of the bundle

Behaviour:
- Pipeline: accept in cycle A -> S1 (address) regs drive rf_rd*_addr in A+1 -> S2 (data) samples rf_rd*_data in A+2 and writes the buffer at end of A+2 -> earliest out_valid in A+3.
- rf_rd*_addr registered; loaded only on accept, otherwise held. Reset value 0.
- in_ready = !rst && (s1_v + s2_v + buf_count) < DEPTH. Counts pre-pop occupancy; no combinational path from out_ready.
- Forwarding: a write is missed by the array read when it occurs in A+1 (S1 cycle) or A+2 (S2 cycle).
  - For each enabled source, S1 records {hit, data} when wr0_en && wr0_addr==src_addr in A+1.
  - S2 overrides when a matching write occurs in A+2 (youngest wins).
  - Final operand priority: S2-cycle write > S1-cycle write > rf_rd*_data.
  - Writes in cycle A or earlier are already in the array; not forwarded.
- Disabled source (in_src_en[i]=0): operand forced to 0; no forwarding.
- Buffer: FIFO, DEPTH entries of {src0,src1,src2,tag}. Pop when out_valid&&out_ready; push and pop in the same cycle are legal.
- Buffered entries are snapshots; writes after A+2 do not update them.
- Overflow is impossible by the credit rule; a push to a full buffer is an assertion failure.
- out_valid = buffer not empty. out_src*/out_tag driven from the FIFO head; stable while out_valid&&!out_ready.
- Reset, including mid-operation: s1_v=s2_v=0, buffer emptied, out_valid=0, out_src*=0, out_tag=0, rf_rd*_addr=0. In-flight requests are dropped; upstream reissues.
- Reset outputs: in_ready=0 during rst, 1 in the first cycle after deassertion.

Decomposition:
- Shared package/definitions header: ADDR_W, DATA_W, TAG_W defaults, source count (3), operand bundle width constant.
- One sub-module: operand_buf_fifo (parameterised DEPTH x width FIFO with count output, push/pop, async reset).
- Forwarding compare logic stays inline.

Test Plan:
- Basic: array holds R5=0x11, R6=0x22, R7=0x33; request srcs {5,6,7}, tag 3, accepted cycle 0 -> rf_rd*_addr = 5/6/7 in cycle 1; out_valid in cycle 3 with {0x11,0x22,0x33}, tag 3.
- Forward S1: write R6<=0xAA in cycle 1 -> out_src1=0xAA. Forward both: write R6<=0xAA in cycle 1 and R6<=0xBB in cycle 2 -> out_src1=0xBB. Write in cycle 0 -> 0xAA read from array.
- Src mask: in_src_en=3'b010 with write to src0 addr in cycle 1 -> out_src0=0, out_src2=0, out_src1 = array value.
- Throughput/backpressure: DEPTH=4, out_ready=1, 20 back-to-back requests -> in_ready stays 1, 20 outputs in order, one per cycle. Hold out_ready=0 -> in_ready falls after exactly 4 accepts; outputs held stable; releasing out_ready drains all 4 in order.
- Reset mid-flight: assert rst async with 3 requests in S1/S2/buffer -> out_valid=0 immediately; after release, no stale bundle is emitted and the next request completes normally.
- Same-cycle push/pop with buffer full at count 1 and DEPTH=1 -> no loss; tags remain in order.
